// File: rtl/exec_pkg.sv
// ============================================================================
// Module : exec_pkg
// Brief  : Shared opcodes, FSM state type and product type for execute_unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package exec_pkg;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h29;
    localparam logic [7:0] OP_AND  = 8'h21;
    localparam logic [7:0] OP_OR   = 8'h09;
    localparam logic [7:0] OP_XOR  = 8'h31;
    localparam logic [7:0] OP_MOV  = 8'h89;
    localparam logic [7:0] OP_GRP3 = 8'hF7;

    localparam logic [2:0] EXT_MUL = 3'd4;
    localparam logic [3:0] REG_RAX = 4'd0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    typedef logic [127:0] prod_t;

    function automatic logic is_mul_op(input logic [7:0] op, input logic [2:0] ext);
        return (op == OP_GRP3) && (ext == EXT_MUL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/execute_unit_mul64_iter.sv
// ============================================================================
// Module : mul64_iter
// Brief  : Iterative unsigned 64x64 shift-add multiplier, one bit per step.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mul64_iter
    import exec_pkg::*;
(
    input  logic        clk,
    input  logic        resetN,
    input  logic        i_start,
    input  logic        i_step,
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    output logic        o_done,
    output prod_t       o_product
);

    logic [63:0] r_mcand;
    prod_t       r_acc;
    logic [5:0]  r_cnt;
    logic [64:0] w_sum;
    prod_t       w_acc_next;

    // Upper half accumulates, lower half holds the not-yet-consumed multiplier
    // bits; both shift right together so the product ends up in r_acc.
    assign w_sum      = {1'b0, r_acc[127:64]} + (r_acc[0] ? {1'b0, r_mcand} : 65'd0);
    assign w_acc_next = {w_sum, r_acc[63:1]};

    assign o_done    = (r_cnt == 6'd63);
    assign o_product = w_acc_next;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_mcand <= 64'd0;
            r_acc   <= '0;
            r_cnt   <= 6'd0;
        end else if (i_start) begin
            r_mcand <= i_a;
            r_acc   <= {64'd0, i_b};
            r_cnt   <= 6'd0;
        end else if (i_step) begin
            r_acc   <= w_acc_next;
            r_cnt   <= r_cnt + 6'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/execute_unit.sv
// ============================================================================
// Module : execute_unit
// Brief  : Execute stage: single-cycle ALU ops, iterative MUL, result register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module execute_unit
    import exec_pkg::*;
(
    input  logic        clk,
    input  logic        resetN,
    input  logic        validIn,
    input  logic [7:0]  opcodeIn,
    input  logic [2:0]  extendedOpcodeIn,
    input  logic [63:0] operandVal1In,
    input  logic [63:0] operandVal2In,
    input  logic [3:0]  destRegIn,
    input  logic        readyIn,
    output logic        stallOut,
    output logic        resultValidOut,
    output logic [63:0] resultOut,
    output logic [63:0] resultHighOut,
    output logic        resultHighValidOut,
    output logic [3:0]  destRegOut,
    output logic        zeroFlagOut,
    output logic        illegalOut
);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_valid;
    logic [63:0] r_res;
    logic [63:0] r_res_hi;
    logic        r_hi_valid;
    logic [3:0]  r_dest;
    logic        r_zf;
    logic        r_ill;

    logic        w_stall;
    logic        w_accept;
    logic        w_is_mul;
    logic        w_mul_start;
    logic        w_mul_step;
    logic        w_mul_done;
    logic        w_mul_finish;
    prod_t       w_product;
    logic [63:0] w_alu_res;
    logic        w_alu_ill;

    assign w_stall      = (r_state == ST_MUL) || (r_valid && !readyIn);
    assign w_accept     = validIn && !w_stall;
    assign w_is_mul     = is_mul_op(opcodeIn, extendedOpcodeIn);
    assign w_mul_start  = w_accept && w_is_mul;
    // The last step is held back while an unretired result occupies the register.
    assign w_mul_step   = (r_state == ST_MUL) && !(w_mul_done && r_valid && !readyIn);
    assign w_mul_finish = w_mul_step && w_mul_done;

    mul64_iter u_mul (
        .clk       (clk),
        .resetN    (resetN),
        .i_start   (w_mul_start),
        .i_step    (w_mul_step),
        .i_a       (operandVal1In),
        .i_b       (operandVal2In),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    always_comb begin
        w_alu_res = 64'd0;
        w_alu_ill = 1'b0;
        case (opcodeIn)
            OP_ADD:  w_alu_res = operandVal1In + operandVal2In;
            OP_SUB:  w_alu_res = operandVal1In - operandVal2In;
            OP_AND:  w_alu_res = operandVal1In & operandVal2In;
            OP_OR:   w_alu_res = operandVal1In | operandVal2In;
            OP_XOR:  w_alu_res = operandVal1In ^ operandVal2In;
            OP_MOV:  w_alu_res = operandVal2In;
            default: w_alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_mul_start)  w_state_next = ST_MUL;
            ST_MUL:  if (w_mul_finish) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_valid    <= 1'b0;
            r_res      <= 64'd0;
            r_res_hi   <= 64'd0;
            r_hi_valid <= 1'b0;
            r_dest     <= 4'd0;
            r_zf       <= 1'b0;
            r_ill      <= 1'b0;
        end else if (w_mul_finish) begin
            r_valid    <= 1'b1;
            r_res      <= w_product[63:0];
            r_res_hi   <= w_product[127:64];
            r_hi_valid <= 1'b1;
            r_dest     <= REG_RAX;
            r_zf       <= (w_product[63:0] == 64'd0);
            r_ill      <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_valid    <= 1'b1;
            r_res      <= w_alu_res;
            r_res_hi   <= 64'd0;
            r_hi_valid <= 1'b0;
            r_dest     <= destRegIn;
            r_zf       <= (w_alu_res == 64'd0);
            r_ill      <= w_alu_ill;
        end else if (r_valid && readyIn) begin
            r_valid    <= 1'b0;
            r_hi_valid <= 1'b0;
        end
    end

    assign stallOut           = w_stall;
    assign resultValidOut     = r_valid;
    assign resultOut          = r_res;
    assign resultHighOut      = r_res_hi;
    assign resultHighValidOut = r_hi_valid;
    assign destRegOut         = r_dest;
    assign zeroFlagOut        = r_zf;
    assign illegalOut         = r_ill;

endmodule

`default_nettype wire

// File: tb/tb_execute_unit.sv
// ============================================================================
// Module : tb_execute_unit
// Brief  : Directed scoreboard bench for execute_unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_execute_unit;

    typedef struct packed {
        logic [63:0] res;
        logic [63:0] hi;
        logic        hv;
        logic [3:0]  dest;
        logic        zf;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        resetN;
    logic        validIn;
    logic [7:0]  opcodeIn;
    logic [2:0]  extendedOpcodeIn;
    logic [63:0] operandVal1In;
    logic [63:0] operandVal2In;
    logic [3:0]  destRegIn;
    logic        readyIn;
    logic        stallOut;
    logic        resultValidOut;
    logic [63:0] resultOut;
    logic [63:0] resultHighOut;
    logic        resultHighValidOut;
    logic [3:0]  destRegOut;
    logic        zeroFlagOut;
    logic        illegalOut;

    int   n_cmp;
    int   n_err;
    exp_t q[$];

    execute_unit dut (
        .clk                (clk),
        .resetN             (resetN),
        .validIn            (validIn),
        .opcodeIn           (opcodeIn),
        .extendedOpcodeIn   (extendedOpcodeIn),
        .operandVal1In      (operandVal1In),
        .operandVal2In      (operandVal2In),
        .destRegIn          (destRegIn),
        .readyIn            (readyIn),
        .stallOut           (stallOut),
        .resultValidOut     (resultValidOut),
        .resultOut          (resultOut),
        .resultHighOut      (resultHighOut),
        .resultHighValidOut (resultHighValidOut),
        .destRegOut         (destRegOut),
        .zeroFlagOut        (zeroFlagOut),
        .illegalOut         (illegalOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t model(input logic [7:0] op, input logic [2:0] ext,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic [3:0] d);
        exp_t         e;
        logic [127:0] p;
        e = '0;
        e.dest = d;
        case (op)
            8'h01: e.res = a + b;
            8'h29: e.res = a - b;
            8'h21: e.res = a & b;
            8'h09: e.res = a | b;
            8'h31: e.res = a ^ b;
            8'h89: e.res = b;
            8'hF7: begin
                if (ext == 3'd4) begin
                    p      = {64'd0, a} * {64'd0, b};
                    e.res  = p[63:0];
                    e.hi   = p[127:64];
                    e.hv   = 1'b1;
                    e.dest = 4'd0;
                end else begin
                    e.ill = 1'b1;
                end
            end
            default: e.ill = 1'b1;
        endcase
        e.zf = (e.res == 64'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] ext,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] d, input bit push);
        validIn          = 1'b1;
        opcodeIn         = op;
        extendedOpcodeIn = ext;
        operandVal1In    = a;
        operandVal2In    = b;
        destRegIn        = d;
        #1;
        chk("stall_at_issue", {63'd0, stallOut}, 64'd0);
        if (push) q.push_back(model(op, ext, a, b, d));
    endtask

    task automatic pop_check(input string tag, output exp_t e);
        e = '0;
        if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = q.pop_front();
            chk({tag, ".valid"}, {63'd0, resultValidOut}, 64'd1);
            chk({tag, ".res"}, resultOut, e.res);
            chk({tag, ".dest"}, {60'd0, destRegOut}, {60'd0, e.dest});
            chk({tag, ".hv"}, {63'd0, resultHighValidOut}, {63'd0, e.hv});
            chk({tag, ".zf"}, {63'd0, zeroFlagOut}, {63'd0, e.zf});
            chk({tag, ".ill"}, {63'd0, illegalOut}, {63'd0, e.ill});
            if (e.hv) chk({tag, ".hi"}, resultHighOut, e.hi);
        end
    endtask

    task automatic wait_result(input string tag, input int max_cycles);
        int i;
        i = 0;
        while (!resultValidOut && i < max_cycles) begin
            next();
            i++;
        end
        if (!resultValidOut) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed no result expected result within %0d cycles", tag, max_cycles);
        end
    endtask

    initial begin
        exp_t e;
        int   n_stall;
        int   first;
        bit   seen;

        n_cmp = 0;
        n_err = 0;
        resetN = 1'b0;
        validIn = 1'b0;
        opcodeIn = 8'd0;
        extendedOpcodeIn = 3'd0;
        operandVal1In = 64'd0;
        operandVal2In = 64'd0;
        destRegIn = 4'd0;
        readyIn = 1'b1;

        repeat (2) next();
        chk("rst.valid", {63'd0, resultValidOut}, 64'd0);
        chk("rst.res", resultOut, 64'd0);
        chk("rst.hi", resultHighOut, 64'd0);
        chk("rst.hv", {63'd0, resultHighValidOut}, 64'd0);
        chk("rst.dest", {60'd0, destRegOut}, 64'd0);
        chk("rst.zf", {63'd0, zeroFlagOut}, 64'd0);
        chk("rst.ill", {63'd0, illegalOut}, 64'd0);
        chk("rst.stall", {63'd0, stallOut}, 64'd0);

        // ADD wrap-around, accepted on the first edge after reset release
        resetN = 1'b1;
        drive(8'h01, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd3, 1'b1);
        next(); validIn = 1'b0;
        pop_check("add_wrap", e);
        next();
        chk("add_retired", {63'd0, resultValidOut}, 64'd0);

        // SUB, SUB, XOR back to back
        drive(8'h29, 3'd0, 64'd100, 64'd58, 4'd1, 1'b1);
        next(); pop_check("sub1", e);
        drive(8'h29, 3'd0, 64'd5, 64'd7, 4'd2, 1'b1);
        next(); pop_check("sub2_borrow", e);
        drive(8'h31, 3'd0, 64'hA5A5_0000_FFFF_1234, 64'h5A5A_0000_FFFF_4321, 4'd4, 1'b1);
        next(); validIn = 1'b0; #1;
        chk("b2b_stall", {63'd0, stallOut}, 64'd0);
        pop_check("xor", e);
        next();
        chk("b2b_retired", {63'd0, resultValidOut}, 64'd0);

        // MOV, OR, illegal opcodes
        drive(8'h89, 3'd0, 64'h1111, 64'hDEAD_BEEF_0000_0042, 4'd6, 1'b1);
        next(); pop_check("mov", e);
        drive(8'h09, 3'd0, 64'hF000_0000_0000_000F, 64'h0F00_0000_0000_00F0, 4'd8, 1'b1);
        next(); pop_check("or", e);
        drive(8'h0F, 3'd0, 64'h1234, 64'h5678, 4'd9, 1'b1);
        next(); pop_check("illegal_0f", e);
        drive(8'hF7, 3'd2, 64'h1234, 64'h5678, 4'd10, 1'b1);
        next(); validIn = 1'b0;
        pop_check("illegal_f7_ext2", e);
        next();

        // MUL all-ones x 2, with unrelated requests presented mid-multiply
        drive(8'hF7, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'd5, 1'b1);
        next(); validIn = 1'b0;
        n_stall = 0;
        first = 0;
        for (int i = 1; i <= 100; i++) begin
            if (i > 1) next();
            if (i >= 10 && i < 20) begin
                validIn = 1'b1; opcodeIn = 8'h09; destRegIn = 4'd7;
            end else begin
                validIn = 1'b0;
            end
            #1;
            if (resultValidOut) begin
                first = i;
                break;
            end
            if (stallOut) n_stall++;
        end
        validIn = 1'b0;
        chk("mul_stall_cycles", 64'(n_stall), 64'd64);
        chk("mul_latency", 64'(first), 64'd65);
        pop_check("mul_ffx2", e);
        next();
        chk("mul_retired", {63'd0, resultValidOut}, 64'd0);

        drive(8'hF7, 3'd4, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 4'd9, 1'b1);
        next(); validIn = 1'b0;
        wait_result("mul2_wait", 80);
        pop_check("mul2", e);
        next();

        // AND held with readyIn low, then replaced by MOV on the retire edge
        readyIn = 1'b0;
        drive(8'h21, 3'd0, 64'hF0F0_F0F0_1234_5678, 64'hFF00_FF00_FFFF_0000, 4'd7, 1'b1);
        next();
        validIn = 1'b1; opcodeIn = 8'h01; operandVal1In = 64'd1; operandVal2In = 64'd1; destRegIn = 4'd1;
        pop_check("and_held", e);
        repeat (4) begin
            next(); #1;
            chk("hold.stall", {63'd0, stallOut}, 64'd1);
            chk("hold.valid", {63'd0, resultValidOut}, 64'd1);
            chk("hold.res", resultOut, e.res);
            chk("hold.dest", {60'd0, destRegOut}, {60'd0, e.dest});
        end
        next();
        readyIn = 1'b1;
        drive(8'h89, 3'd0, 64'd0, 64'h0000_0000_CAFE_F00D, 4'd11, 1'b1);
        next(); validIn = 1'b0;
        pop_check("replace_mov", e);
        next();
        chk("replace_retired", {63'd0, resultValidOut}, 64'd0);

        // reset in the middle of a multiply
        drive(8'hF7, 3'd4, 64'd12345, 64'd678, 4'd0, 1'b0);
        next(); validIn = 1'b0;
        repeat (29) next();
        resetN = 1'b0;
        #1;
        chk("midrst.valid", {63'd0, resultValidOut}, 64'd0);
        chk("midrst.res", resultOut, 64'd0);
        chk("midrst.hi", resultHighOut, 64'd0);
        chk("midrst.hv", {63'd0, resultHighValidOut}, 64'd0);
        chk("midrst.dest", {60'd0, destRegOut}, 64'd0);
        chk("midrst.zf", {63'd0, zeroFlagOut}, 64'd0);
        chk("midrst.ill", {63'd0, illegalOut}, 64'd0);
        chk("midrst.stall", {63'd0, stallOut}, 64'd0);
        next();
        resetN = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            next();
            if (resultValidOut) seen = 1'b1;
        end
        chk("midrst.no_result", {63'd0, seen}, 64'd0);
        drive(8'h01, 3'd0, 64'd40, 64'd2, 4'd12, 1'b1);
        next(); validIn = 1'b0;
        pop_check("add_after_rst", e);
        next();

        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
